// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Shared definitions for the data-RAM front end: default geometry, the FSM
//   state encoding (3-bit) and the address range check.
// ---------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 9;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RDATA = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Word addresses 0..depth-1 are backed by RAM; anything else is rejected.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Request/response front end for the single-port data RAM. Accepts one
//   load or store at a time, sequences the RAM strobes and returns a
//   one-cycle response pulse. Out-of-range addresses complete with rsp_err
//   without ever strobing the RAM.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   req_valid/req_ready   request handshake (see below)
//   req_we/addr/wdata     request: 1 = store, word address, store data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             last captured load data (holds across stores/errors)
//   rsp_err               address out of range, qualified by rsp_valid
//   ram_write_en/read_en  RAM strobes, decoded from FSM state only
//   ram_addr/ram_data_in  RAM address / write data, from latched request regs
//   ram_data_out          RAM read data, valid the cycle after ram_read_en
//
// Handshake: a request transfers on a posedge where req_valid && req_ready.
// req_ready is high only while IDLE; the requester holds req_valid and its
// payload stable until the transfer. req_valid while busy is ignored.
//
// Latency from accept to rsp_valid: load 3, store 2, error 1 cycles.
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_write_en,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              write_en_q;
  logic              read_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              in_range_d;

  assign in_range_d = addr_in_range(32'(req_addr), 32'(DEPTH));

  // Strobe and response flags are registered together with the state, so
  // each one is asserted exactly while the FSM sits in the matching state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b0;
            if (!in_range_d) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (req_we) begin
              state_q    <= ST_WRITE;
              write_en_q <= 1'b1;
            end else begin
              state_q   <= ST_READ;
              read_en_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_READ: begin
          // RAM registers the read address on this edge; data follows.
          state_q <= ST_RDATA;
        end
        ST_RDATA: begin
          rsp_rdata_q <= ram_data_out;
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign ram_write_en = write_en_q;
  assign ram_read_en  = read_en_q;
  assign ram_addr     = addr_q;
  assign ram_data_in  = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Bench for mem_access_ctrl paired with a behavioural single-port RAM
//   (write on posedge, read address registered). Directed table, reset and
//   back-to-back corner sequences, then random traffic against a reference
//   model built from the request-level rules.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          ram_write_en;
  logic          ram_read_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // ---------------- single-port RAM ----------------
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  logic [4:0]    ram_raddr = 5'd0;

  always @(posedge clk) begin
    if (ram_write_en) ram_mem[ram_addr[4:0]] <= ram_data_in;
    if (ram_read_en)  ram_raddr <= ram_addr[4:0];
  end
  assign ram_data_out = ram_mem[ram_raddr];

  // ---------------- reference model ----------------
  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic [DW-1:0] model_last;
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] preload(input int i);
    return 16'hA000 | 16'(i);
  endfunction

  // Request-level rules: out of range -> error after 1 cycle; store -> 2;
  // load -> 3 and updates the held read data.
  task automatic model_apply(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata,
                             output int lat, output logic err,
                             output logic [DW-1:0] rdata);
    err = (int'(addr) >= DEPTH);
    if (err) lat = 1;
    else if (we) begin
      lat = 2;
      model_mem[int'(addr)] = wdata;
    end else begin
      lat = 3;
      model_last = model_mem[int'(addr)];
    end
    rdata = model_last;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Called just after a negedge with the DUT idle. Issues one request and
  // follows it through to the cycle after its response pulse.
  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int exp_lat,
                        input logic exp_err, input logic [DW-1:0] exp_rdata);
    int n;
    bit got;
    exp_q.push_back(exp_rdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid = 1'b0;
        if (exp_err)
          chk("err_no_strobe", {30'd0, ram_write_en, ram_read_en}, 32'd0);
        else if (we) begin
          chk("wr_strobe", {30'd0, ram_write_en, ram_read_en}, 32'd2);
          chk("wr_addr", 32'(ram_addr), 32'(addr));
          chk("wr_data", 32'(ram_data_in), 32'(wdata));
        end else begin
          chk("rd_strobe", {30'd0, ram_write_en, ram_read_en}, 32'd1);
          chk("rd_addr", 32'(ram_addr), 32'(addr));
        end
      end else begin
        chk("strobes_idle", {30'd0, ram_write_en, ram_read_en}, 32'd0);
      end
      if (rsp_valid) got = 1'b1;
      else chk("ready_busy", 32'(req_ready), 32'd0);
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("latency", 32'(n), 32'(exp_lat));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
    @(negedge clk);
    chk("rsp_one_cycle", {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic          err;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat;
    logic err;
    logic [DW-1:0] rd;
    int cnt;
    logic [AW-1:0] seen_addr;

    vecs[0] = '{1'b1, 9'd5,   16'hBEEF, 2, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 9'd5,   16'h0000, 3, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b1, 9'd32,  16'h1234, 1, 1'b1, 16'hBEEF};
    vecs[3] = '{1'b0, 9'd0,   16'h0000, 3, 1'b0, 16'hA000};
    vecs[4] = '{1'b1, 9'd31,  16'h5555, 2, 1'b0, 16'hA000};
    vecs[5] = '{1'b0, 9'd31,  16'h0000, 3, 1'b0, 16'h5555};
    vecs[6] = '{1'b0, 9'd511, 16'h0000, 1, 1'b1, 16'h5555};
    vecs[7] = '{1'b0, 9'd32,  16'h0000, 1, 1'b1, 16'h5555};
    vecs[8] = '{1'b1, 9'd0,   16'h0F0F, 2, 1'b0, 16'h5555};
    vecs[9] = '{1'b0, 9'd0,   16'h0000, 3, 1'b0, 16'h0F0F};

    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i]   = preload(i);
      model_mem[i] = preload(i);
    end
    model_last = '0;

    // ---- reset with a pending request ----
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 9'd7;
    req_wdata = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_strobes", {30'd0, ram_write_en, ram_read_en}, 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_data_in), 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("no_accept_in_rst", 32'(ram_mem[7]), 32'(preload(7)));

    // ---- table ----
    for (int i = 0; i < 10; i++) begin
      model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, err, rd);
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
             vecs[i].err, vecs[i].rdata);
    end
    chk("oor_not_written", 32'(ram_mem[0]), 32'h0F0F);

    // ---- reset in the middle of a load ----
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 9'd5;
    req_wdata = '0;
    @(negedge clk);             // accepted
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;               // sampled at T+2
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      cnt += int'(rsp_valid);
    end
    chk("abort_no_rsp", 32'(cnt), 32'd0);
    chk("abort_rdata_cleared", 32'(rsp_rdata), 32'd0);
    model_last = '0;
    model_apply(1'b0, 9'd5, 16'h0, lat, err, rd);
    do_req(1'b0, 9'd5, 16'h0, lat, err, rd);
    chk("reload_beef", 32'(rd), 32'hBEEF);

    // ---- request held high while busy, address changed ----
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 9'd5;
    cnt = 0;
    seen_addr = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) req_addr = 9'd31;
      if (n == 5) req_valid = 1'b0;
      if (ram_read_en) begin
        cnt++;
        seen_addr = ram_addr;
      end
      if (n == 3) begin
        chk("b2b_rsp1", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata1", 32'(rsp_rdata), 32'(model_mem[5]));
      end
      if (n == 4) chk("b2b_ready_idle", 32'(req_ready), 32'd1);
      if (n == 7) begin
        chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata2", 32'(rsp_rdata), 32'(model_mem[31]));
      end
    end
    chk("b2b_accepts", 32'(cnt), 32'd2);
    chk("b2b_second_addr", 32'(seen_addr), 32'd31);
    model_last = model_mem[31];

    // ---- random traffic ----
    for (int i = 0; i < 60; i++) begin
      logic          r_we;
      logic [AW-1:0] r_addr;
      logic [DW-1:0] r_data;
      r_we   = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(32, 511))
                                           : 9'($urandom_range(0, 31));
      r_data = 16'($urandom);
      model_apply(r_we, r_addr, r_data, lat, err, rd);
      do_req(r_we, r_addr, r_data, lat, err, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
